regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Unified GPR+FPR register file for the RV32IMF core with a per-register busy scoreboard.
//  Sits in decode: serves NUM_READ source operands (rs3 for fused FP ops), takes two write-back ports
//  (single-cycle ALU path, long-latency MUL/DIV/FPU path) and raises issue_stall on RAW/WAW hazards.
//  Replaces the separate GPR/FPR files and their unclocked write-data selection.
// PARAMETERS
//  XLEN      32  data width of every register
//  NUM_READ   3  read ports (>=2); port i addresses bank rs_bank[i]
//  CNT_W      7  width of outstanding counter (holds 0..64)
// PORTS
//  clk          in   1              clock, all state updates on rising edge
//  rst          in   1              asynchronous, active-high reset
//  rs_bank      in   NUM_READ       per-port bank select: 0=GPR, 1=FPR
//  rs_addr      in   NUM_READ*5     per-port register index, port i at [5i+4:5i]
//  rs_used      in   NUM_READ       port i is a real source of the issuing instruction
//  rs_data      out  NUM_READ*XLEN  per-port read data, port i at [XLEN*i+XLEN-1:XLEN*i]
//  issue_valid  in   1              decode presents an instruction this cycle
//  issue_long   in   1              instruction completes via wb1 (MUL/DIV/FPU)
//  issue_we     in   1              instruction writes a destination
//  issue_bank   in   1              destination bank
//  issue_rd     in   5              destination index
//  issue_stall  out  1              hazard: instruction must be held in decode
//  wb0_en/bank/addr/data in 1/1/5/XLEN  single-cycle write-back; never touches the scoreboard
//  wb1_en/bank/addr/data in 1/1/5/XLEN  long-latency write-back; clears busy[bank][addr]
//  outstanding  out  CNT_W          number of busy bits currently set
// BEHAVIOUR
//  - Reset (async, immediate, also mid-operation): all 64 registers=0, all busy=0, outstanding=0.
//  - GPR x0: reads return 0, writes ignored, never marked busy. FPR f0 is an ordinary register.
//  - Read is combinational. Bypass priority: wb1 match > wb0 match > array. A match needs same bank,
//    same addr, en=1, and is not x0 in GPR.
//  - Write: both ports write at the clock edge. If both target the same register, wb1 wins.
//  - clr[b][r] = wb1_en & wb1_bank==b & wb1_addr==r, but not for GPR x0.
//  - eff_busy = busy & ~clr. A register being written back this cycle is readable via bypass.
//  - RAW on port i: rs_used[i] & eff_busy[rs_bank[i]][rs_addr[i]].
//  - WAW: issue_we & eff_busy[issue_bank][issue_rd].
//  - issue_stall = issue_valid & (any RAW | WAW). It is combinational, so it is 0 after reset.
//  - accept = issue_valid & ~issue_stall.
//  - set = accept & issue_long & issue_we & not (GPR x0).
//  - Next busy: set has priority over clr for the same register. The new op owns the register.
//  - Outstanding update: outstanding_next = outstanding + set - (clr & busy).
//    - Only a clear of a bit that is actually set decrements.
//    - Same-register set+clr leaves the count unchanged.
//    - Never wraps: 64 busy bits max, and CNT_W is sized to hold that.
//  - wb1 to a non-busy register: writes data only, no count change. wb0 to a busy register
//    (misuse): writes data, busy is unchanged.
//  - Latency: a write is visible on rs_data the same cycle via bypass, and from the array the next cycle.
// TESTING
//  1 Reset mid-run with 5 busy regs -> same cycle busy all 0, outstanding=0, rs_data=0 on all ports.
//  2 Write wb0 GPR x0=0xDEADBEEF, then read x0 -> 0. Write wb0 FPR f0=0x3F800000, then read -> 0x3F800000.
//  3 Issue long FPR f5, then next issue reads f5 -> issue_stall=1 until wb1 f5=0x40490FDB.
//    In that cycle stall=0 and rs_data=0x40490FDB (bypass). outstanding goes 1->0.
//  4 Same cycle: wb0 and wb1 both write GPR x7 (0x11 and 0x22) -> read x7 next cycle = 0x22.
//  5 Same cycle: wb1 clears GPR x9 and an accepted long issue targets x9 -> x9 stays busy, outstanding unchanged.
//  6 WAW: GPR x3 busy, issue_we rd=x3 with no sources used -> stall=1. Issue with rs_used=0 and issue_we=0 -> stall=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Unified 32 GPR + 32 FPR register file with a per-register busy scoreboard for decode.
// Latency: reads and issue_stall are combinational, with same-cycle write-back bypass. Writes land at the clock edge.
// Backpressure: issue_stall holds an instruction in decode while it has a RAW or WAW hazard on a busy register.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   rs_bank/rs_addr/rs_used       per-read-port bank (0=GPR, 1=FPR), index and "real source" flag
//   rs_data                       per-read-port data, port i at [XLEN*i +: XLEN]
//   issue_valid/long/we/bank/rd   instruction presented by decode
//   issue_stall                   hazard: hold the instruction
//   wb0_*                         single-cycle write-back; never touches the scoreboard
//   wb1_*                         long-latency write-back; clears the busy bit of its target
//   outstanding                   number of busy bits currently set
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_READ = 3,
    parameter int CNT_W    = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_READ-1:0]      rs_bank,
    input  logic [NUM_READ*5-1:0]    rs_addr,
    input  logic [NUM_READ-1:0]      rs_used,
    output logic [NUM_READ*XLEN-1:0] rs_data,
    input  logic                     issue_valid,
    input  logic                     issue_long,
    input  logic                     issue_we,
    input  logic                     issue_bank,
    input  logic [4:0]               issue_rd,
    output logic                     issue_stall,
    input  logic                     wb0_en,
    input  logic                     wb0_bank,
    input  logic [4:0]               wb0_addr,
    input  logic [XLEN-1:0]          wb0_data,
    input  logic                     wb1_en,
    input  logic                     wb1_bank,
    input  logic [4:0]               wb1_addr,
    input  logic [XLEN-1:0]          wb1_data,
    output logic [CNT_W-1:0]         outstanding
);

    // Both banks live in one array indexed by {bank, addr}; index 0 is GPR x0.
    logic [XLEN-1:0] regs [64];
    logic [63:0]     busy;

    logic [5:0]  wb0_idx;
    logic [5:0]  wb1_idx;
    logic [5:0]  iss_idx;
    logic        wb0_ok;
    logic        wb1_ok;
    logic [63:0] clr;
    logic [63:0] eff_busy;
    logic [63:0] set_v;
    logic [63:0] busy_next;
    logic [NUM_READ-1:0] raw;
    logic        waw;
    logic        accept;
    logic        set_ok;
    logic        dec;

    assign wb0_idx = {wb0_bank, wb0_addr};
    assign wb1_idx = {wb1_bank, wb1_addr};
    assign iss_idx = {issue_bank, issue_rd};

    // Writes to x0 are dropped everywhere: no data, no bypass, no scoreboard effect.
    assign wb0_ok = wb0_en & (wb0_idx != 6'd0);
    assign wb1_ok = wb1_en & (wb1_idx != 6'd0);

    always_comb begin
        clr = '0;
        if (wb1_ok) begin
            clr[wb1_idx] = 1'b1;
        end
    end

    // A register completing this cycle is already readable through the bypass,
    // so it no longer blocks dependants.
    assign eff_busy = busy & ~clr;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [5:0] idx;
        assign idx = {rs_bank[i], rs_addr[5*i +: 5]};
        // Bypass priority: wb1 > wb0 > array; x0 is hard-wired zero.
        assign rs_data[XLEN*i +: XLEN] =
            (idx == 6'd0)              ? '0       :
            (wb1_ok && wb1_idx == idx) ? wb1_data :
            (wb0_ok && wb0_idx == idx) ? wb0_data :
                                         regs[idx];
        assign raw[i] = rs_used[i] & eff_busy[idx];
    end

    assign waw         = issue_we & eff_busy[iss_idx];
    assign issue_stall = issue_valid & ((|raw) | waw);
    assign accept      = issue_valid & ~issue_stall;
    assign set_ok      = accept & issue_long & issue_we & (iss_idx != 6'd0);

    always_comb begin
        set_v = '0;
        if (set_ok) begin
            set_v[iss_idx] = 1'b1;
        end
    end

    // The new long op owns the register, so a set overrides a same-cycle clear.
    assign busy_next = eff_busy | set_v;

    // Only clearing a bit that was actually set reduces the count.
    assign dec = |(clr & busy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            outstanding <= '0;
            for (int k = 0; k < 64; k++) begin
                regs[k] <= '0;
            end
        end else begin
            busy        <= busy_next;
            outstanding <= outstanding + CNT_W'(set_ok) - CNT_W'(dec);
            if (wb0_ok) begin
                regs[wb0_idx] <= wb0_data;
            end
            // Issued after wb0 so wb1 wins when both target the same register.
            if (wb1_ok) begin
                regs[wb1_idx] <= wb1_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
    localparam int XLEN = 32;
    localparam int NR   = 3;
    localparam int CW   = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     rs_bank;
    logic [NR*5-1:0]   rs_addr;
    logic [NR-1:0]     rs_used;
    logic [NR*XLEN-1:0] rs_data;
    logic              issue_valid, issue_long, issue_we, issue_bank;
    logic [4:0]        issue_rd;
    logic              issue_stall;
    logic              wb0_en, wb0_bank;
    logic [4:0]        wb0_addr;
    logic [XLEN-1:0]   wb0_data;
    logic              wb1_en, wb1_bank;
    logic [4:0]        wb1_addr;
    logic [XLEN-1:0]   wb1_data;
    logic [CW-1:0]     outstanding;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural register contents and pending long-latency writes.
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    regfile_scoreboard #(.XLEN(XLEN), .NUM_READ(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs_bank(rs_bank), .rs_addr(rs_addr), .rs_used(rs_used), .rs_data(rs_data),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_we(issue_we),
        .issue_bank(issue_bank), .issue_rd(issue_rd), .issue_stall(issue_stall),
        .wb0_en(wb0_en), .wb0_bank(wb0_bank), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_bank(wb1_bank), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 32; a++) begin
                m_reg[b][a]  = '0;
                m_busy[b][a] = 1'b0;
            end
    endtask

    function automatic bit is_x0(input bit b, input int a);
        return (b == 1'b0) && (a == 0);
    endfunction

    // Pending write still outstanding after this cycle's wb1 completion is taken into account.
    function automatic bit blocked(input bit b, input int a);
        if (wb1_en && wb1_bank == b && int'(wb1_addr) == a) return 1'b0;
        return m_busy[b][a];
    endfunction

    function automatic logic [31:0] exp_read(input bit b, input int a);
        if (is_x0(b, a)) return 32'h0;
        if (wb1_en && wb1_bank == b && int'(wb1_addr) == a) return wb1_data;
        if (wb0_en && wb0_bank == b && int'(wb0_addr) == a) return wb0_data;
        return m_reg[b][a];
    endfunction

    function automatic bit exp_stall();
        bit h = 1'b0;
        if (!issue_valid) return 1'b0;
        for (int p = 0; p < NR; p++)
            if (rs_used[p] && blocked(rs_bank[p], int'(rs_addr[5*p +: 5]))) h = 1'b1;
        if (issue_we && blocked(issue_bank, int'(issue_rd))) h = 1'b1;
        return h;
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 32; a++)
                c += int'(m_busy[b][a]);
        return c;
    endfunction

    task automatic idle();
        rs_bank = '0; rs_addr = '0; rs_used = '0;
        issue_valid = 0; issue_long = 0; issue_we = 0; issue_bank = 0; issue_rd = '0;
        wb0_en = 0; wb0_bank = 0; wb0_addr = '0; wb0_data = '0;
        wb1_en = 0; wb1_bank = 0; wb1_addr = '0; wb1_data = '0;
    endtask

    task automatic set_src(input int p, input bit u, input bit b, input logic [4:0] a);
        rs_used[p] = u;
        rs_bank[p] = b;
        rs_addr[5*p +: 5] = a;
    endtask

    task automatic issue(input bit lng, input bit we, input bit b, input logic [4:0] rd);
        issue_valid = 1; issue_long = lng; issue_we = we; issue_bank = b; issue_rd = rd;
    endtask

    task automatic check_outputs();
        for (int p = 0; p < NR; p++)
            chk($sformatf("rs_data%0d", p), rs_data[XLEN*p +: XLEN],
                exp_read(rs_bank[p], int'(rs_addr[5*p +: 5])));
        chk("issue_stall", 32'(issue_stall), 32'(exp_stall()));
        chk("outstanding", 32'(outstanding), 32'(exp_count()));
    endtask

    // Called at posedge+1 with inputs set: check mid-cycle, then advance model over the edge.
    task automatic tick();
        bit acc;
        #2;
        check_outputs();
        acc = issue_valid && !exp_stall();
        @(posedge clk);
        if (wb0_en && !is_x0(wb0_bank, int'(wb0_addr))) m_reg[wb0_bank][wb0_addr] = wb0_data;
        if (wb1_en && !is_x0(wb1_bank, int'(wb1_addr))) begin
            m_reg[wb1_bank][wb1_addr]  = wb1_data;
            m_busy[wb1_bank][wb1_addr] = 1'b0;
        end
        if (acc && issue_long && issue_we && !is_x0(issue_bank, int'(issue_rd)))
            m_busy[issue_bank][issue_rd] = 1'b1;
        #1;
    endtask

    initial begin
        int nb;
        int pick;
        int bl_b [$];
        int bl_a [$];

        idle();
        model_reset();
        rst = 1'b1;
        set_src(0, 1, 1, 5'd1);
        set_src(1, 1, 1, 5'd31);
        #3;
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        chk("reset_stall", 32'(issue_stall), 32'd0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Five long ops in flight, then an asynchronous reset mid-cycle.
        for (int r = 1; r <= 5; r++) begin
            idle(); issue(1, 1, 0, 5'(r));
            wb0_en = 1; wb0_bank = 1; wb0_addr = 5'(r); wb0_data = 32'h100 + r;
            tick();
        end
        idle();
        chk("pre_reset_outstanding", 32'(outstanding), 32'd5);
        set_src(0, 1, 0, 5'd1); set_src(1, 1, 0, 5'd2); set_src(2, 1, 1, 5'd3);
        issue(0, 1, 0, 5'd4);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outstanding", 32'(outstanding), 32'd0);
        chk("midreset_rs0", rs_data[31:0], 32'd0);
        chk("midreset_rs1", rs_data[63:32], 32'd0);
        chk("midreset_rs2", rs_data[95:64], 32'd0);
        chk("midreset_stall", 32'(issue_stall), 32'd0);
        model_reset();
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // x0 ignores writes, f0 is ordinary.
        idle(); wb0_en = 1; wb0_bank = 0; wb0_addr = 0; wb0_data = 32'hDEADBEEF;
        set_src(0, 1, 0, 5'd0);
        tick();
        idle(); set_src(0, 1, 0, 5'd0);
        #1 chk("x0_read", rs_data[31:0], 32'd0);
        tick();
        idle(); wb0_en = 1; wb0_bank = 1; wb0_addr = 0; wb0_data = 32'h3F800000;
        tick();
        idle(); set_src(1, 1, 1, 5'd0);
        #1 chk("f0_read", rs_data[63:32], 32'h3F800000);
        tick();

        // RAW on f5 until wb1 completes it, then bypass.
        idle(); issue(1, 1, 1, 5'd5);
        tick();
        idle(); issue(0, 0, 0, 5'd0); set_src(0, 1, 1, 5'd5);
        #1 chk("raw_stall", 32'(issue_stall), 32'd1);
        tick();
        tick();
        wb1_en = 1; wb1_bank = 1; wb1_addr = 5'd5; wb1_data = 32'h40490FDB;
        #1;
        chk("raw_release_stall", 32'(issue_stall), 32'd0);
        chk("raw_bypass", rs_data[31:0], 32'h40490FDB);
        chk("raw_cnt_before", 32'(outstanding), 32'd1);
        tick();
        idle();
        #1 chk("raw_cnt_after", 32'(outstanding), 32'd0);

        // wb0 and wb1 on x7 in the same cycle: wb1 wins.
        idle();
        wb0_en = 1; wb0_bank = 0; wb0_addr = 5'd7; wb0_data = 32'h11;
        wb1_en = 1; wb1_bank = 0; wb1_addr = 5'd7; wb1_data = 32'h22;
        tick();
        idle(); set_src(2, 1, 0, 5'd7);
        #1 chk("dual_write_x7", rs_data[95:64], 32'h22);
        tick();

        // Same-cycle clear and set of x9.
        idle(); issue(1, 1, 0, 5'd9);
        tick();
        idle(); issue(1, 1, 0, 5'd9);
        wb1_en = 1; wb1_bank = 0; wb1_addr = 5'd9; wb1_data = 32'h99;
        #1 chk("setclr_stall", 32'(issue_stall), 32'd0);
        tick();
        idle(); issue(0, 0, 0, 5'd0); set_src(0, 1, 0, 5'd9);
        #1;
        chk("setclr_still_busy", 32'(issue_stall), 32'd1);
        chk("setclr_cnt", 32'(outstanding), 32'd1);
        tick();
        idle(); wb1_en = 1; wb1_bank = 0; wb1_addr = 5'd9; wb1_data = 32'h9A;
        tick();

        // WAW on x3.
        idle(); issue(1, 1, 0, 5'd3);
        tick();
        idle(); issue(0, 1, 0, 5'd3);
        #1 chk("waw_stall", 32'(issue_stall), 32'd1);
        tick();
        idle(); issue(0, 0, 0, 5'd3);
        #1 chk("no_we_no_stall", 32'(issue_stall), 32'd0);
        tick();
        idle(); wb1_en = 1; wb1_bank = 0; wb1_addr = 5'd3; wb1_data = 32'h33;
        tick();

        // Randomised traffic on a small register window to provoke hazards.
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            for (int p = 0; p < NR; p++)
                set_src(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) != 0)
                issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) == 0) begin
                wb0_en = 1; wb0_bank = 1'($urandom_range(0, 1));
                wb0_addr = 5'($urandom_range(0, 7)); wb0_data = $urandom;
            end
            bl_b.delete(); bl_a.delete();
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 32; a++)
                    if (m_busy[b][a]) begin bl_b.push_back(b); bl_a.push_back(a); end
            nb = bl_b.size();
            if (nb > 0 && $urandom_range(0, 2) == 0) begin
                pick = $urandom_range(0, nb - 1);
                wb1_en = 1; wb1_bank = 1'(bl_b[pick]); wb1_addr = 5'(bl_a[pick]); wb1_data = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                wb1_en = 1; wb1_bank = 1'($urandom_range(0, 1));
                wb1_addr = 5'($urandom_range(0, 7)); wb1_data = $urandom;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
